// File: rtl/id_ex_hazard_pipe.sv
// ID/EX pipeline register with load-use hazard detection, one-bubble stall insertion,
// EX-resolved flush, and saturating stall/flush event counters.
module id_ex_hazard_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             RegWrite,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic             ALUSrc,
  input  logic [5:0]       EXTOp,
  input  logic [4:0]       ALUOp,
  input  logic [4:0]       NPCOp,
  input  logic [1:0]       WDSel,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_flush,
  output logic             ex_valid,
  output logic             ex_RegWrite,
  output logic             ex_MemWrite,
  output logic             ex_MemRead,
  output logic             ex_ALUSrc,
  output logic [5:0]       ex_EXTOp,
  output logic [4:0]       ex_ALUOp,
  output logic [4:0]       ex_NPCOp,
  output logic [1:0]       ex_WDSel,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rd1,
  output logic [XLEN-1:0]  ex_rd2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {ACT_LOAD, ACT_BUBBLE, ACT_FLUSH} act_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic             valid_q, valid_d, regw_q, regw_d, memw_q, memw_d;
  logic             memr_q, memr_d, alusrc_q, alusrc_d;
  logic [5:0]       extop_q, extop_d;
  logic [4:0]       aluop_q, aluop_d, npcop_q, npcop_d;
  logic [1:0]       wdsel_q, wdsel_d;
  logic [XLEN-1:0]  pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CNT_W-1:0] scnt_q, scnt_d, fcnt_q, fcnt_d;
  logic             hazard;
  act_e             act;

  // A load in EX whose destination is an operand actually read by ID cannot forward in time.
  assign hazard = valid_q & memr_q & (rd_q != 5'd0) & id_valid &
                  ((id_use_rs1 & (id_rs1 == rd_q)) | (id_use_rs2 & (id_rs2 == rd_q)));
  assign stall  = hazard & ~ex_flush;

  always_comb begin
    act = ACT_LOAD;
    if (ex_flush)   act = ACT_FLUSH;
    else if (stall) act = ACT_BUBBLE;
  end

  always_comb begin
    valid_d = valid_q;  regw_d  = regw_q;  memw_d  = memw_q;  memr_d  = memr_q;
    alusrc_d = alusrc_q; extop_d = extop_q; aluop_d = aluop_q; npcop_d = npcop_q;
    wdsel_d = wdsel_q;  pc_d    = pc_q;    rd1_d   = rd1_q;   rd2_d   = rd2_q;
    imm_d   = imm_q;    rs1_d   = rs1_q;   rs2_d   = rs2_q;   rd_d    = rd_q;
    scnt_d  = scnt_q;   fcnt_d  = fcnt_q;
    case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        valid_d = 1'b0; regw_d = 1'b0; memw_d = 1'b0; memr_d = 1'b0; alusrc_d = 1'b0;
        extop_d = '0;   aluop_d = '0;  npcop_d = '0;  wdsel_d = '0;  rd_d = '0;
        if (act == ACT_FLUSH) fcnt_d = sat_inc(fcnt_q);
        else                  scnt_d = sat_inc(scnt_q);
      end
      default: begin
        // Invalid slots never carry live control, whatever the decoder produced.
        valid_d  = id_valid;
        regw_d   = id_valid & RegWrite;
        memw_d   = id_valid & MemWrite;
        memr_d   = id_valid & MemRead;
        alusrc_d = id_valid & ALUSrc;
        extop_d  = id_valid ? EXTOp : '0;
        aluop_d  = id_valid ? ALUOp : '0;
        npcop_d  = id_valid ? NPCOp : '0;
        wdsel_d  = id_valid ? WDSel : '0;
        pc_d  = id_pc;  rd1_d = id_rd1; rd2_d = id_rd2; imm_d = id_imm;
        rs1_d = id_rs1; rs2_d = id_rs2; rd_d  = id_rd;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0; regw_q <= 1'b0; memw_q <= 1'b0; memr_q <= 1'b0; alusrc_q <= 1'b0;
      extop_q <= '0; aluop_q <= '0; npcop_q <= '0; wdsel_q <= '0;
      pc_q <= '0; rd1_q <= '0; rd2_q <= '0; imm_q <= '0;
      rs1_q <= '0; rs2_q <= '0; rd_q <= '0;
      scnt_q <= '0; fcnt_q <= '0;
    end else begin
      valid_q <= valid_d; regw_q <= regw_d; memw_q <= memw_d; memr_q <= memr_d;
      alusrc_q <= alusrc_d; extop_q <= extop_d; aluop_q <= aluop_d; npcop_q <= npcop_d;
      wdsel_q <= wdsel_d; pc_q <= pc_d; rd1_q <= rd1_d; rd2_q <= rd2_d; imm_q <= imm_d;
      rs1_q <= rs1_d; rs2_q <= rs2_d; rd_q <= rd_d;
      scnt_q <= scnt_d; fcnt_q <= fcnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_RegWrite = regw_q;
  assign ex_MemWrite = memw_q;
  assign ex_MemRead  = memr_q;
  assign ex_ALUSrc   = alusrc_q;
  assign ex_EXTOp    = extop_q;
  assign ex_ALUOp    = aluop_q;
  assign ex_NPCOp    = npcop_q;
  assign ex_WDSel    = wdsel_q;
  assign ex_pc       = pc_q;
  assign ex_rd1      = rd1_q;
  assign ex_rd2      = rd2_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign stall_cnt   = scnt_q;
  assign flush_cnt   = fcnt_q;

endmodule
